// File: rtl/ciphertext_receiver.sv
// Serial ciphertext receiver: deframes MSB-first bits, optionally XOR-decrypts with a rotating key byte, buffers in a FIFO.
// Optional decrypt stage enabled by defining CIPHERTEXT_RECEIVER_DECRYPT_EN.
module ciphertext_receiver #(
    parameter int unsigned MSG_SIZE   = 8,
    parameter int unsigned KEY_SIZE   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          iData_in,
    input  logic                          iData_flag,
    input  logic [KEY_SIZE-1:0]           iKey,
    output logic [MSG_SIZE-1:0]           oData,
    output logic                          oValid,
    input  logic                          iReady,
    output logic [$clog2(FIFO_DEPTH):0]   oCount,
    output logic                          oOverflow,
    output logic                          oFrame_error
);

    localparam int unsigned CNT_W = $clog2(MSG_SIZE + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, STORE, WAIT_LOW} state_t;

    state_t                state;
    state_t                state_n;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_n;
    logic [MSG_SIZE-1:0]   shift_reg;
    logic                  shift_en;
    logic                  push_req;
    logic                  err_c;
    logic [MSG_SIZE-1:0]   push_data;

    logic [MSG_SIZE-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_next;
    logic [OCC_W-1:0]      count_n;
    logic [MSG_SIZE-1:0]   head_n;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic                  drop;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and framing control; nothing moves while ena is low
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        err_c     = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (iData_flag) begin
                        shift_en  = 1'b1;
                        bit_cnt_n = CNT_W'(1);
                        state_n   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (iData_flag) begin
                        shift_en  = 1'b1;
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(MSG_SIZE - 1)) begin
                            state_n = STORE;
                        end
                    end else begin
                        err_c     = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                    end
                end
                STORE: begin
                    push_req  = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = iData_flag ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!iData_flag) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Deserializer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            oFrame_error <= 1'b0;
        end else begin
            bit_cnt      <= bit_cnt_n;
            oFrame_error <= err_c;
            if (shift_en) begin
                shift_reg <= {shift_reg[MSG_SIZE-2:0], iData_in};
            end
        end
    end

`ifdef CIPHERTEXT_RECEIVER_DECRYPT_EN
    localparam int unsigned KEY_BYTES = KEY_SIZE / MSG_SIZE;
    localparam int unsigned KSEL_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KSEL_W-1:0] key_sel;

    // Key byte advances on every completed frame, including dropped ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_sel <= '0;
        end else if (push_req) begin
            key_sel <= (key_sel == KSEL_W'(KEY_BYTES - 1)) ? '0 : key_sel + KSEL_W'(1);
        end
    end

    assign push_data = shift_reg ^ iKey[32'(key_sel) * MSG_SIZE +: MSG_SIZE];
`else
    logic unused_key;

    assign unused_key = ^iKey;
    assign push_data  = shift_reg;
`endif

    assign pop     = ena && oValid && iReady;
    assign full    = (oCount == OCC_W'(FIFO_DEPTH));
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && !push_ok;
    assign rd_next = rd_ptr + PTR_W'(1);

    // Occupancy and registered head; head looks ahead so back-to-back pops need no bubble
    always_comb begin
        count_n = oCount;
        head_n  = oData;
        case ({push_ok, pop})
            2'b10:   count_n = oCount + OCC_W'(1);
            2'b01:   count_n = oCount - OCC_W'(1);
            default: count_n = oCount;
        endcase
        if (pop) begin
            head_n = (oCount == OCC_W'(1)) ? push_data : mem[rd_next];
        end else if (push_ok && oCount == '0) begin
            head_n = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oCount    <= '0;
            oValid    <= 1'b0;
            oData     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            oCount <= count_n;
            oValid <= (count_n != '0);
            oData  <= head_n;
            if (drop) begin
                oOverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ciphertext_receiver.sv
// Scoreboard bench for ciphertext_receiver; expected bytes are queued at frame completion and checked on pop.
module tb_ciphertext_receiver;

`ifdef CIPHERTEXT_RECEIVER_DECRYPT_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        iData_in = 1'b0;
    logic        iData_flag = 1'b0;
    logic [31:0] iKey = '0;
    logic [7:0]  oData;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [2:0]  oCount;
    logic        oOverflow;
    logic        oFrame_error;

    int          n_tests = 0;
    int          n_fail = 0;
    int          mcount = 0;
    int          ksel_m = 0;
    bit          ovf_m = 1'b0;
    logic [7:0]  exp_q[$];
    logic [31:0] key_v = '0;

    ciphertext_receiver dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(iData_in), .iData_flag(iData_flag),
        .iKey(iKey), .oData(oData), .oValid(oValid), .iReady(iReady), .oCount(oCount),
        .oOverflow(oOverflow), .oFrame_error(oFrame_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] d);
        logic [7:0] kb;
        kb = key_v[ksel_m*8 +: 8];
        return DEC ? (d ^ kb) : d;
    endfunction

    // One clock: score the pop/push that this edge performs, then check outputs after it
    task automatic tick(input bit st, input bit short_end, input logic [7:0] fr);
        bit         pop_m;
        logic [7:0] e;
        pop_m = ena && (mcount > 0) && iReady;
        if (pop_m) begin
            e = exp_q.pop_front();
            check("pop_data", 32'(oData), 32'(e));
        end
        if (st) begin
            if (mcount < 4 || pop_m) begin
                exp_q.push_back(model_byte(fr));
                mcount++;
            end else begin
                ovf_m = 1'b1;
            end
            ksel_m = (ksel_m + 1) % 4;
        end
        if (pop_m) mcount--;
        @(posedge clk);
        #1;
        check("valid", 32'(oValid), 32'(mcount != 0));
        check("count", 32'(oCount), 32'(mcount));
        check("overflow", 32'(oOverflow), 32'(ovf_m));
        check("frame_err", 32'(oFrame_error), 32'(short_end));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ena        = 1'b1;
        iData_flag = 1'b0;
        mcount     = 0;
        ksel_m     = 0;
        ovf_m      = 1'b0;
        exp_q.delete();
        check("rst_data", 32'(oData), 32'h0);
        check("rst_valid", 32'(oValid), 32'h0);
        check("rst_count", 32'(oCount), 32'h0);
        check("rst_overflow", 32'(oOverflow), 32'h0);
        check("rst_frame_err", 32'(oFrame_error), 32'h0);
    endtask

    task automatic pause();
        ena        = 1'b0;
        iData_flag = 1'b0;
        repeat (3) begin
            iData_in = 1'($urandom);
            tick(1'b0, 1'b0, 8'h0);
        end
        ena        = 1'b1;
        iData_flag = 1'b1;
    endtask

    // nbits<8 makes a short frame; extra keeps the flag high past the last bit
    task automatic send_frame(input logic [7:0] data, input int nbits, input int extra,
                              input int pause_at, input bit rdy_store);
        iData_flag = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at) pause();
            iData_in = data[7-i];
            tick(1'b0, 1'b0, 8'h0);
        end
        if (nbits < 8) begin
            iData_flag = 1'b0;
            tick(1'b0, 1'b1, 8'h0);
        end else begin
            if (rdy_store) iReady = 1'b1;
            iData_flag = (extra > 0);
            iData_in   = 1'($urandom);
            tick(1'b1, 1'b0, data);
            if (rdy_store) iReady = 1'b0;
            for (int j = 1; j < extra; j++) begin
                iData_in = 1'($urandom);
                tick(1'b0, 1'b0, 8'h0);
            end
            if (extra > 0) begin
                iData_flag = 1'b0;
                tick(1'b0, 1'b0, 8'h0);
            end
        end
    endtask

    task automatic drain();
        iReady = 1'b1;
        for (int k = 0; k < 12 && mcount > 0; k++) tick(1'b0, 1'b0, 8'h0);
        check("drained", 32'(exp_q.size()), 32'h0);
        iReady = 1'b0;
    endtask

    initial begin
        do_reset();

        key_v = 32'hA5C33C5A;
        iKey  = key_v;
        send_frame(8'h1B, 8, 0, -1, 1'b0);
        check("first_head", 32'(oData), DEC ? 32'h41 : 32'h1B);
        send_frame(8'h7D, 8, 0, -1, 1'b0);
        drain();

        send_frame(8'hAA, 5, 0, -1, 1'b0);
        send_frame(8'h3C, 8, 0, -1, 1'b0);
        send_frame(8'hF0, 8, 4, -1, 1'b0);
        send_frame(8'h96, 8, 0, 3, 1'b0);
        drain();

        do_reset();
        key_v  = 32'h0;
        iKey   = key_v;
        for (int f = 0; f < 5; f++) send_frame(8'(8'h10 + f), 8, 0, -1, 1'b0);
        check("ovf_count", 32'(oCount), 32'h4);
        check("ovf_sticky", 32'(oOverflow), 32'h1);
        drain();
        tick(1'b0, 1'b0, 8'h0);

        do_reset();
        key_v = 32'h1234_5678;
        iKey  = key_v;
        for (int f = 0; f < 4; f++) send_frame(8'(8'hC0 ^ f), 8, 0, -1, 1'b0);
        send_frame(8'h5E, 8, 0, -1, 1'b1);
        check("full_pp_count", 32'(oCount), 32'h4);
        check("full_pp_ovf", 32'(oOverflow), 32'h0);
        drain();

        key_v = 32'hA5C33C5A;
        iKey  = key_v;
        send_frame(8'h33, 8, 0, -1, 1'b0);
        iData_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iData_in = 1'($urandom);
            tick(1'b0, 1'b0, 8'h0);
        end
        do_reset();
        send_frame(8'h1B, 8, 0, -1, 1'b0);
        check("post_rst_key0", 32'(oData), DEC ? 32'h41 : 32'h1B);
        drain();

        for (int f = 0; f < 20; f++) begin
            iReady = 1'($urandom);
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0) ? 6 : 8,
                       int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 4 : -1, 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
